mult_seq_shift_add: RTL
=======================

Name: mult_seq_shift_add

Overview:
- Parametrised sequential shift-add multiplier. It is the successor to the fixed 8-bit datapath and control-unit multiplier.
- Generalised to WIDTH-bit operands, with a per-operation signed/unsigned mode and a start/busy/done handshake.
- Datapath and control FSM live in one block.
- Sits between operand producers and any consumer of the 2*WIDTH-bit product.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement operands and product; 0 = unsigned. Sampled with start.
- multiplicand  input  WIDTH  operand A; sampled with start.
- multiplier  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  2*WIDTH  registered result; holds until the next completion.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=0; all internal registers (acc, areg, breg, cnt, neg) = 0.
- Reset mid-operation aborts the operation. No done is produced and product reads 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge (call it edge 0), load:
  - areg = |multiplicand|, zero-extended to 2*WIDTH.
  - breg = |multiplier|.
  - acc = 0; cnt = WIDTH; state -> RUN.
  - |x| is x when signed_op=0. When signed_op=1, |x| is the two's-complement magnitude; the most negative value maps to 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - neg = signed_op & (multiplicand[MSB] ^ multiplier[MSB]).
- IDLE, start=0: no change.
- RUN, each edge:
  - if breg[0] then acc += areg (2*WIDTH-bit add, no overflow possible).
  - areg <<= 1; breg >>= 1; cnt -= 1.
- RUN -> DONE at the edge where cnt becomes 0. At that same edge, product = neg ? -(acc_next) : acc_next, truncated to 2*WIDTH bits.
- DONE: done=1 for exactly one cycle; -> IDLE at the next edge.
- Latency: start sampled at edge 0, product and done valid after edge WIDTH, done drops at edge WIDTH+1. busy is high for WIDTH+1 cycles.
- Back-to-back: a new start is accepted no earlier than edge WIDTH+2, i.e. the first edge seen in IDLE.
- start or operand changes in RUN/DONE are ignored; operands are captured only at load.
- Zero operands: the full WIDTH iterations run unless the optional feature is enabled. Product = 0 with neg cleared, so -0 = 0.
- Signed extremes (WIDTH=8): -128 * -128 = +16384 (0x4000); -128 * 127 = -16256 (0xC080). Both fit in 2*WIDTH bits.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in RUN, the transition to DONE also occurs at any edge where breg_next == 0. Product is written as above; latency = (index of the highest set bit of |multiplier|) + 1 edges, minimum 1.
  - |multiplier| = 0: done after edge 1.
  - |multiplier| = 1: done after edge 1.
- Undefined: fixed latency of WIDTH edges for every operand.

Test Plan:
- WIDTH=8, unsigned 13*11 -> product=0x008F at edge 8 after start, done high exactly one cycle, busy high 9 cycles.
- Unsigned 255*255 -> 0xFE01. Then back-to-back at the first IDLE edge: 0*77 -> 0x0000, with product holding 0xFE01 until the second done.
- signed_op=1:
  - -3*5 -> 0xFFF1
  - -128*-128 -> 0x4000
  - -128*1 -> 0xFF80
  - 0x80 with signed_op=0, times 1 -> 0x0080
- Start 6*7, then pulse start with 9*9 at edge 3 -> first result 0x002A only. The second start is ignored: no second done.
- Assert rst_n low between edges 4 and 5 of 200*100 -> busy, done and product go 0 immediately, with no done. After release, 12*12 -> 0x0090.
- MUL_EARLY_EXIT_EN defined: 200*1 -> 0x00C8 with done after edge 1; 3*0x40 -> 0x00C0 after edge 7. Undefined: both complete after edge 8.

Source files
------------

// File: rtl/mult_seq_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_shift_add
// Brief    : Parametrised sequential shift-add multiplier with a start/busy/
//            done handshake and per-operation signed/unsigned mode.
//            Signed operands are converted to magnitudes at load, multiplied
//            unsigned, and the sign is restored when the product is written.
//            Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining
//            multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_shift_add #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_areg;
    logic [WIDTH-1:0]     r_breg;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_breg_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_finish;

    // Operand magnitudes; the most negative value negates to 2^(WIDTH-1),
    // which is still exact when read as unsigned.
    always_comb begin
        w_abs_a = (signed_op && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
        w_abs_b = (signed_op && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
    end

    // One shift-add step and the end-of-operation decision.
    always_comb begin
        w_acc_next  = r_breg[0] ? (r_acc + r_areg) : r_acc;
        w_breg_next = r_breg >> 1;
        w_cnt_next  = r_cnt - CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
        w_finish    = (w_cnt_next == '0) || (w_breg_next == '0);
`else
        w_finish    = (w_cnt_next == '0);
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_acc     <= '0;
            r_areg    <= '0;
            r_breg    <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_areg  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_breg  <= w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        // A zero operand yields +0, so the sign is dropped.
                        r_neg   <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1])
                                   & (|multiplicand) & (|multiplier);
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc  <= w_acc_next;
                    r_areg <= r_areg << 1;
                    r_breg <= w_breg_next;
                    r_cnt  <= w_cnt_next;
                    if (w_finish) begin
                        r_product <= r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != c_IDLE);
    assign done    = (r_state == c_DONE);
    assign product = r_product;

endmodule
`default_nettype wire
